// File: rtl/rob_cmpl_if.sv
// Bundle of the FU completion ports, flush/head inputs and ROB update / CDB outputs.
// No logic: pure wiring between the FUs, the ROB and the completion arbiter.
// Widths come from the global `ROB_IDX / `PRF_IDX macros; the fallbacks below apply only if the build sets neither.
`ifndef ROB_IDX
`define ROB_IDX 5
`endif
`ifndef PRF_IDX
`define PRF_IDX 6
`endif

interface rob_cmpl_if #(
  parameter int NUM_FU = 4
);
  logic [NUM_FU-1:0]          fu_valid;
  logic [NUM_FU*`ROB_IDX-1:0] fu_rob_idx;
  logic [NUM_FU*`PRF_IDX-1:0] fu_pdest;
  logic [NUM_FU-1:0]          fu_bt;
  logic [NUM_FU*64-1:0]       fu_ba;
  logic [NUM_FU-1:0]          fu_ready;

  logic                       branch_miss;
  logic [`ROB_IDX-1:0]        rob_head;

  logic                       dup1_req;
  logic                       dup2_req;
  logic [`ROB_IDX-1:0]        rob_idx_out1;
  logic [`ROB_IDX-1:0]        rob_idx_out2;
  logic                       bt_ex_out1;
  logic                       bt_ex_out2;
  logic [63:0]                ba_ex_out1;
  logic [63:0]                ba_ex_out2;
  logic [`PRF_IDX-1:0]        cdb_pdest1;
  logic [`PRF_IDX-1:0]        cdb_pdest2;

  // FU / ROB side: drives completions and flush, observes ready and updates.
  modport master (
    output fu_valid, fu_rob_idx, fu_pdest, fu_bt, fu_ba, branch_miss, rob_head,
    input  fu_ready, dup1_req, dup2_req, rob_idx_out1, rob_idx_out2,
    input  bt_ex_out1, bt_ex_out2, ba_ex_out1, ba_ex_out2, cdb_pdest1, cdb_pdest2
  );

  // Arbiter side.
  modport slave (
    input  fu_valid, fu_rob_idx, fu_pdest, fu_bt, fu_ba, branch_miss, rob_head,
    output fu_ready, dup1_req, dup2_req, rob_idx_out1, rob_idx_out2,
    output bt_ex_out1, bt_ex_out2, ba_ex_out1, ba_ex_out2, cdb_pdest1, cdb_pdest2
  );
endinterface

// File: rtl/rob_cmpl.sv
// Completion arbiter: per-FU one-entry holding regs, picks up to two per cycle for ROB update + CDB broadcast.
// Latency: accepted at edge E0, granted in the following cycle, registered on dupN_req after edge E1 (2 edges).
// Backpressure: fu_ready[i] = !hold_valid[i] | grant[i] (same-cycle refill); branch_miss squashes everything held.
// Optional CMPL_AGE_PRIO_EN: oldest-first selection by (rob_idx - rob_head); otherwise round-robin from rr.
`ifndef ROB_IDX
`define ROB_IDX 5
`endif
`ifndef PRF_IDX
`define PRF_IDX 6
`endif

module rob_cmpl #(
  parameter int NUM_FU = 4
) (
  input  logic       clk,
  input  logic       reset,
  rob_cmpl_if.slave  bus
);
  localparam int RW = `ROB_IDX;
  localparam int PW = `PRF_IDX;
  localparam int FW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  // Holding registers, one per FU.
  logic [NUM_FU-1:0] hold_valid;
  logic [RW-1:0]     hold_rob   [NUM_FU];
  logic [PW-1:0]     hold_pdest [NUM_FU];
  logic [NUM_FU-1:0] hold_bt;
  logic [63:0]       hold_ba    [NUM_FU];

  // Selection results for this cycle.
  logic              sel1_vld;
  logic              sel2_vld;
  logic [FW-1:0]     sel1_idx;
  logic [FW-1:0]     sel2_idx;
  logic [NUM_FU-1:0] grant;
  logic [NUM_FU-1:0] xfer;

`ifdef CMPL_AGE_PRIO_EN
  logic [RW-1:0] age [NUM_FU];
  logic [RW-1:0] best1;
  logic [RW-1:0] best2;

  // Age of each held entry relative to the ROB head; subtraction wraps at 2^ROB_IDX.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      age[i] = hold_rob[i] - bus.rob_head;
    end
  end

  // Oldest-first: smallest age goes to slot 1, next smallest to slot 2.
  always_comb begin
    sel1_vld = 1'b0;
    sel1_idx = '0;
    sel2_vld = 1'b0;
    sel2_idx = '0;
    best1    = '1;
    best2    = '1;
    for (int i = 0; i < NUM_FU; i++) begin
      if (hold_valid[i] && (!sel1_vld || (age[i] < best1))) begin
        sel1_vld = 1'b1;
        sel1_idx = FW'(i);
        best1    = age[i];
      end
    end
    for (int i = 0; i < NUM_FU; i++) begin
      if (hold_valid[i] && (FW'(i) != sel1_idx) && (!sel2_vld || (age[i] < best2))) begin
        sel2_vld = 1'b1;
        sel2_idx = FW'(i);
        best2    = age[i];
      end
    end
  end
`else
  logic [FW-1:0] rr;
  logic [FW-1:0] rr_nxt;
  logic [FW:0]   scan_sum;
  logic [FW-1:0] scan_idx;
  logic [FW:0]   last_sum;
  logic          unused_rob_head;

  // Head pointer only matters for age ordering.
  assign unused_rob_head = ^bus.rob_head;

  // Round-robin scan starting at rr, wrapping modulo NUM_FU; first two valid entries win.
  always_comb begin
    sel1_vld = 1'b0;
    sel1_idx = '0;
    sel2_vld = 1'b0;
    sel2_idx = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      scan_sum = {1'b0, rr} + (FW+1)'(k);
      if (scan_sum >= (FW+1)'(NUM_FU)) begin
        scan_sum = scan_sum - (FW+1)'(NUM_FU);
      end
      scan_idx = scan_sum[FW-1:0];
      if (hold_valid[scan_idx]) begin
        if (!sel1_vld) begin
          sel1_vld = 1'b1;
          sel1_idx = scan_idx;
        end else if (!sel2_vld) begin
          sel2_vld = 1'b1;
          sel2_idx = scan_idx;
        end
      end
    end
  end

  // Next pointer is one past the last granted FU, modulo NUM_FU.
  always_comb begin
    last_sum = {1'b0, (sel2_vld ? sel2_idx : sel1_idx)} + (FW+1)'(1);
    if (last_sum >= (FW+1)'(NUM_FU)) begin
      last_sum = last_sum - (FW+1)'(NUM_FU);
    end
    rr_nxt = last_sum[FW-1:0];
  end

  // Pointer only advances on a real (non-squashed) grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr <= '0;
    end else if (sel1_vld && !bus.branch_miss) begin
      rr <= rr_nxt;
    end
  end
`endif

  // One-hot grant vector from the two slot selections.
  always_comb begin
    grant = '0;
    if (sel1_vld) grant[sel1_idx] = 1'b1;
    if (sel2_vld) grant[sel2_idx] = 1'b1;
  end

  // Ready is forced low during reset so nothing is accepted into cleared state.
  assign bus.fu_ready = reset ? '0 : (~hold_valid | grant);
  assign xfer         = bus.fu_valid & bus.fu_ready;

  // Holding registers: flush wins, then capture (refill), then release on grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= '0;
      hold_bt    <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        hold_rob[i]   <= '0;
        hold_pdest[i] <= '0;
        hold_ba[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (xfer[i]) begin
          hold_rob[i]   <= bus.fu_rob_idx[i*RW +: RW];
          hold_pdest[i] <= bus.fu_pdest[i*PW +: PW];
          hold_bt[i]    <= bus.fu_bt[i];
          hold_ba[i]    <= bus.fu_ba[i*64 +: 64];
        end
        if (bus.branch_miss) begin
          hold_valid[i] <= 1'b0;
        end else if (xfer[i]) begin
          hold_valid[i] <= 1'b1;
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Registered ROB update / CDB outputs; unfilled slots keep their previous data.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.dup1_req     <= 1'b0;
      bus.dup2_req     <= 1'b0;
      bus.rob_idx_out1 <= '0;
      bus.rob_idx_out2 <= '0;
      bus.bt_ex_out1   <= 1'b0;
      bus.bt_ex_out2   <= 1'b0;
      bus.ba_ex_out1   <= '0;
      bus.ba_ex_out2   <= '0;
      bus.cdb_pdest1   <= '0;
      bus.cdb_pdest2   <= '0;
    end else begin
      bus.dup1_req <= sel1_vld && !bus.branch_miss;
      bus.dup2_req <= sel2_vld && !bus.branch_miss;
      if (sel1_vld && !bus.branch_miss) begin
        bus.rob_idx_out1 <= hold_rob[sel1_idx];
        bus.bt_ex_out1   <= hold_bt[sel1_idx];
        bus.ba_ex_out1   <= hold_ba[sel1_idx];
        bus.cdb_pdest1   <= hold_pdest[sel1_idx];
      end
      if (sel2_vld && !bus.branch_miss) begin
        bus.rob_idx_out2 <= hold_rob[sel2_idx];
        bus.bt_ex_out2   <= hold_bt[sel2_idx];
        bus.ba_ex_out2   <= hold_ba[sel2_idx];
        bus.cdb_pdest2   <= hold_pdest[sel2_idx];
      end
    end
  end

`ifndef SYNTHESIS
  // Two live entries naming the same ROB slot would complete it twice.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        for (int j = i + 1; j < NUM_FU; j++) begin
          dup_rob_idx_chk: assert (!(hold_valid[i] && hold_valid[j] && (hold_rob[i] == hold_rob[j])));
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_rob_cmpl.sv
// Scoreboard bench for rob_cmpl: directed completions per FU, expected updates queued in grant order.
// A negedge monitor pops and compares every dupN_req; direct checks cover reset, latency and flush.
`ifndef ROB_IDX
`define ROB_IDX 5
`endif
`ifndef PRF_IDX
`define PRF_IDX 6
`endif

module tb_rob_cmpl;
  localparam int N  = 4;
  localparam int RW = `ROB_IDX;
  localparam int PW = `PRF_IDX;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [RW-1:0] rob;
    logic          bt;
    logic [63:0]   ba;
    logic [PW-1:0] pdest;
  } item_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rob_cmpl_if #(.NUM_FU(N)) bus ();
  rob_cmpl #(.NUM_FU(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  item_t fmem [N][DEPTH];
  int    fhead [N];
  int    ftail [N];
  item_t exp_q [$];
  int    checks   = 0;
  int    failures = 0;
  logic  watch_rdy3 = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic item_t mk(input int r);
    item_t it;
    it.rob   = RW'(r);
    it.bt    = r[0];
    it.ba    = 64'h8000_0000 + 64'(r) * 64'h40;
    it.pdest = PW'(r + 7);
    return it;
  endfunction

  task automatic add(input int fu, input item_t it);
    fmem[fu][ftail[fu]] = it;
    ftail[fu]++;
  endtask

  // Drive each FU port with the head of its pending list.
  task automatic present();
    item_t it;
    for (int i = 0; i < N; i++) begin
      if (fhead[i] < ftail[i]) begin
        it = fmem[i][fhead[i]];
        bus.fu_valid[i]           = 1'b1;
        bus.fu_rob_idx[i*RW +: RW] = it.rob;
        bus.fu_bt[i]              = it.bt;
        bus.fu_ba[i*64 +: 64]     = it.ba;
        bus.fu_pdest[i*PW +: PW]  = it.pdest;
      end else begin
        bus.fu_valid[i] = 1'b0;
      end
    end
  endtask

  // One clock: note handshakes at negedge, retire them after the edge, present next items.
  task automatic cycle();
    logic [N-1:0] xf;
    @(negedge clk);
    xf = bus.fu_valid & bus.fu_ready;
    if (watch_rdy3 && bus.fu_valid[3]) chk("bp_ready3", 64'(bus.fu_ready[3]), 64'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (xf[i]) fhead[i]++;
    end
    present();
    #1;
  endtask

  task automatic cmp_upd(input int slot, input item_t got);
    item_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL upd%0d_unexpected actual rob=%0d required=no update", slot, got.rob);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        failures++;
        $display("FAIL upd%0d actual rob=%0d bt=%0d ba=%0h pdest=%0d required rob=%0d bt=%0d ba=%0h pdest=%0d",
                 slot, got.rob, got.bt, got.ba, got.pdest, e.rob, e.bt, e.ba, e.pdest);
      end
    end
  endtask

  // Monitor: every presented update is checked against the head of the expected queue.
  initial begin
    item_t g;
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        checks++;
        if (bus.dup2_req && !bus.dup1_req) begin
          failures++;
          $display("FAIL slot_order actual dup1=0 dup2=1 required dup1=1");
        end
        if (bus.dup1_req) begin
          g = '{rob: bus.rob_idx_out1, bt: bus.bt_ex_out1, ba: bus.ba_ex_out1, pdest: bus.cdb_pdest1};
          cmp_upd(1, g);
        end
        if (bus.dup2_req) begin
          g = '{rob: bus.rob_idx_out2, bt: bus.bt_ex_out2, ba: bus.ba_ex_out2, pdest: bus.cdb_pdest2};
          cmp_upd(2, g);
        end
      end
    end
  end

  initial begin
    item_t it;
    reset           = 1'b1;
    bus.branch_miss = 1'b0;
    bus.rob_head    = '0;
    bus.fu_valid    = '0;
    bus.fu_rob_idx  = '0;
    bus.fu_pdest    = '0;
    bus.fu_bt       = '0;
    bus.fu_ba       = '0;
    for (int i = 0; i < N; i++) begin
      fhead[i] = 0;
      ftail[i] = 0;
    end

    // Reset held for two edges, then released.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_low", 64'(bus.fu_ready), 64'h0);
    reset = 1'b0;
    #1;
    chk("rst_ready_all", 64'(bus.fu_ready), 64'hF);
    chk("rst_dup1", 64'(bus.dup1_req), 64'd0);
    chk("rst_dup2", 64'(bus.dup2_req), 64'd0);
    chk("rst_rob1", 64'(bus.rob_idx_out1), 64'd0);
    chk("rst_ba1", bus.ba_ex_out1, 64'd0);
    chk("rst_cdb2", 64'(bus.cdb_pdest2), 64'd0);

    // Single completion on FU2: visible after two edges, slot 2 empty.
    it = '{rob: RW'(5), bt: 1'b1, ba: 64'h1000, pdest: PW'(17)};
    add(2, it);
    exp_q.push_back(it);
    present();
    cycle();
    chk("single_dup1_e1", 64'(bus.dup1_req), 64'd0);
    cycle();
    chk("single_dup1_e2", 64'(bus.dup1_req), 64'd1);
    chk("single_dup2_e2", 64'(bus.dup2_req), 64'd0);
    chk("single_rob1", 64'(bus.rob_idx_out1), 64'd5);
    chk("single_pdest1", 64'(bus.cdb_pdest1), 64'd17);
    repeat (2) cycle();

    // Mid-run reset: outputs return to zero, rr back to 0 (rr was 3 here).
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_rob1", 64'(bus.rob_idx_out1), 64'd0);
    chk("mid_rst_ba1", bus.ba_ex_out1, 64'd0);
    chk("mid_rst_bt1", 64'(bus.bt_ex_out1), 64'd0);

    // Round-robin fairness from rr=0: pairs {0,1},{2,3},{0,1},{2,3}.
    for (int r = 8; r < 16; r++) begin
      add((r - 8) % 4, mk(r));
      exp_q.push_back(mk(r));
    end
    present();
    repeat (7) cycle();
    chk("rr_drained", 64'(exp_q.size()), 64'd0);

    // Flush: FU0/FU1 captured, branch_miss next cycle; FU3 transfer in that cycle is dropped.
    add(0, mk(20));
    add(1, mk(21));
    present();
    cycle();
    bus.branch_miss = 1'b1;
    add(3, mk(22));
    present();
    cycle();
    bus.branch_miss = 1'b0;
    #1;
    chk("flush_dup1_a", 64'(bus.dup1_req), 64'd0);
    chk("flush_dup2_a", 64'(bus.dup2_req), 64'd0);
    chk("flush_ready", 64'(bus.fu_ready), 64'hF);
    cycle();
    chk("flush_dup1_b", 64'(bus.dup1_req), 64'd0);
    chk("flush_dup2_b", 64'(bus.dup2_req), 64'd0);

    // rr must still be 0 after the flush: FU0 takes slot 1 ahead of FU2.
    add(0, mk(23));
    add(2, mk(24));
    exp_q.push_back(mk(23));
    exp_q.push_back(mk(24));
    present();
    repeat (3) cycle();

    // Backpressure from rr=3: FU3 and FU1 granted together every cycle, FU3 never stalls.
    add(3, mk(25)); add(3, mk(26)); add(3, mk(27));
    add(1, mk(28)); add(1, mk(29)); add(1, mk(30));
    exp_q.push_back(mk(25)); exp_q.push_back(mk(28));
    exp_q.push_back(mk(26)); exp_q.push_back(mk(29));
    exp_q.push_back(mk(27)); exp_q.push_back(mk(30));
    watch_rdy3 = 1'b1;
    present();
    repeat (4) cycle();
    watch_rdy3 = 1'b0;
    repeat (2) cycle();
    chk("bp_fu3_done", 64'(ftail[3] - fhead[3]), 64'd0);

`ifdef CMPL_AGE_PRIO_EN
    // Oldest-first across the index wrap: head 30, ages 31->1, 0->2, 2->4, 29->31.
    bus.rob_head = RW'(30);
    add(0, mk(2)); add(1, mk(31)); add(2, mk(29)); add(3, mk(0));
    exp_q.push_back(mk(31)); exp_q.push_back(mk(0));
    exp_q.push_back(mk(2));  exp_q.push_back(mk(29));
    present();
    repeat (4) cycle();
`endif

    repeat (3) cycle();
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
